// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared constants and types for the DAC SPI loopback receiver.
// Frame layout is DB23:18 don't care, DB17:16 power-down, DB15:0 data.
package dac_spi_pkg;

  localparam int          DAC_FRAME_BITS = 24;
  localparam logic [15:0] DAC_MIDSCALE   = 16'h8000;

  localparam logic [1:0] PD_NORMAL   = 2'b00;
  localparam logic [1:0] PD_1K       = 2'b01;
  localparam logic [1:0] PD_100K     = 2'b10;
  localparam logic [1:0] PD_TRISTATE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_SYNC
  } rx_state_t;

  function automatic logic [15:0] to_signed(input logic [15:0] d);
    return {~d[15], d[14:0]};
  endfunction

endpackage

// File: rtl/dac_spi_receiver_sync.sv
// spi_line_sync: SYNC/SCLK/DIN synchronizer with SCLK falling-edge detect.
// s_valid_o rises once the chain holds real pin samples after reset.
module spi_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  input  logic sclk_i,
  input  logic din_i,
  output logic s_sync_o,
  output logic s_din_o,
  output logic s_valid_o,
  output logic edge_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] din_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '1;
      sclk_q      <= '0;
      din_q       <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= sync_i;
      sclk_q[0] <= sclk_i;
      din_q[0]  <= din_i;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        sclk_q[i] <= sclk_q[i-1];
        din_q[i]  <= din_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign s_sync_o  = sync_q[SYNC_STAGES-1];
  assign s_din_o   = din_q[SYNC_STAGES-1];
  assign s_valid_o = fill_q[SYNC_STAGES-1];
  assign edge_o    = sclk_prev_q & ~sclk_q[SYNC_STAGES-1];
  assign fall_o    = edge_o & ~s_sync_o;

endmodule

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: rebuilds DAC words from the 3-wire SPI stream.
// Define DAC_RX_FRAME_CHECK_EN to flag short and overrun frames on frame_err.
module dac_spi_receiver
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        SYNC,
  input  logic        SCLK,
  input  logic        DIN,
  output logic [15:0] data_out,
  output logic [15:0] data_signed,
  output logic [1:0]  pd_mode,
  output logic        data_valid,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        frame_err
);

  localparam logic [4:0] LAST_BIT = 5'(DAC_FRAME_BITS - 1);
`ifdef DAC_RX_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic s_sync, s_din, s_valid, sclk_edge, fall;

  spi_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_i    (dataclk),
    .rst_i    (reset),
    .sync_i   (SYNC),
    .sclk_i   (SCLK),
    .din_i    (DIN),
    .s_sync_o (s_sync),
    .s_din_o  (s_din),
    .s_valid_o(s_valid),
    .edge_o   (sclk_edge),
    .fall_o   (fall)
  );

  rx_state_t   state_q;
  logic [4:0]  cnt_q;
  logic [17:0] sr_q;
  logic [17:0] sr_d;
  logic [15:0] data_q;
  logic [1:0]  pd_q;
  logic        valid_q;
  logic        err_q;
  logic        armed_q;
  logic        ovr_q;
  logic        take;
  logic        done;
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  // 24th edge coinciding with the SYNC rise still completes the frame
  assign take = fall | (sclk_edge & s_sync & (cnt_q == LAST_BIT));
  assign done = (state_q == SHIFT) & take & (cnt_q == LAST_BIT);
  assign sr_d = {sr_q[16:0], s_din};
  assign frame_cnt_d = frame_cnt_q + {15'd0, done};

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= DAC_MIDSCALE;
      pd_q    <= PD_NORMAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!s_sync && armed_q) begin
            state_q <= SHIFT;
            armed_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= {4'd0, fall};
            sr_q    <= {17'd0, fall & s_din};
          end else if (s_sync && s_valid) begin
            armed_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (take) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 5'd1;
            if (done) begin
              data_q  <= sr_d[15:0];
              pd_q    <= sr_d[17:16];
              valid_q <= 1'b1;
              state_q <= s_sync ? IDLE : WAIT_SYNC;
              armed_q <= s_sync;
            end
          end else if (s_sync) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            err_q   <= CHECK_EN && (cnt_q != 5'd0);
          end
        end
        WAIT_SYNC: begin
          if (s_sync) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            err_q   <= CHECK_EN && ovr_q;
          end else if (fall) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge dataclk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign data_out    = data_q;
  assign data_signed = to_signed(data_q);
  assign pd_mode     = pd_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_cnt_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb_dac_spi_receiver: randomized SPI frames against a frame-level model.
// Expected frame_err pulses follow DAC_RX_FRAME_CHECK_EN.
module tb_dac_spi_receiver;

  localparam int S = 2;
`ifdef DAC_RX_FRAME_CHECK_EN
  localparam int ERRW = 1;
`else
  localparam int ERRW = 0;
`endif

  logic        dataclk = 1'b0;
  logic        reset   = 1'b1;
  logic        SYNC    = 1'b1;
  logic        SCLK    = 1'b0;
  logic        DIN     = 1'b0;
  logic [15:0] data_out, data_signed, frame_count;
  logic [1:0]  pd_mode;
  logic        data_valid, busy, frame_err;

  dac_spi_receiver #(.SYNC_STAGES(S)) dut (
    .dataclk    (dataclk),
    .reset      (reset),
    .SYNC       (SYNC),
    .SCLK       (SCLK),
    .DIN        (DIN),
    .data_out   (data_out),
    .data_signed(data_signed),
    .pd_mode    (pd_mode),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_count(frame_count),
    .frame_err  (frame_err)
  );

  always #5 dataclk = ~dataclk;

  int cyc = 0;
  always @(posedge dataclk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic [1:0]  pd;
  } vexp_t;

  vexp_t       vq[$];
  int          eq[$];
  logic [17:0] seen[$];
  int          err_seen = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  int          rst_gen = 0, rst_seen = 0;
  int          frc_gen = 0, frc_seen = 0;
  logic [15:0] m_data = 16'h8000;
  logic [1:0]  m_pd = 2'd0;
  logic [15:0] m_cnt = 16'd0;

  // Frame-level model: outputs change only at the predicted valid cycle
  always @(negedge dataclk) begin
    bit ev, ee, stale;
    ev = 1'b0;
    ee = 1'b0;
    stale = 1'b0;
    if (rst_gen != rst_seen) begin
      rst_seen = rst_gen;
      m_data = 16'h8000;
      m_pd = 2'd0;
      m_cnt = 16'd0;
    end
    if (frc_gen != frc_seen) begin
      frc_seen = frc_gen;
      m_cnt = 16'hFFFF;
    end
    if (chk_en) begin
      if (vq.size() > 0 && vq[0].c == cyc) begin
        ev = 1'b1;
        m_data = vq[0].d;
        m_pd = vq[0].pd;
        m_cnt = m_cnt + 16'd1;
        vq.delete(0);
      end
      if (eq.size() > 0 && eq[0] == cyc) begin
        ee = 1'b1;
        eq.delete(0);
      end
      if ((vq.size() > 0 && vq[0].c < cyc) || (eq.size() > 0 && eq[0] < cyc))
        stale = 1'b1;
      if (data_valid) seen.push_back({pd_mode, data_out});
      if (frame_err) err_seen++;
      checks++;
      if (data_valid !== ev || data_out !== m_data || pd_mode !== m_pd ||
          frame_count !== m_cnt || frame_err !== ee || stale ||
          data_signed !== {~m_data[15], m_data[14:0]}) begin
        errors++;
        $display("FAIL cycle %0d: dv %b/%b data %h/%h pd %0d/%0d cnt %h/%h err %b/%b sgn %h stale %b",
                 cyc, data_valid, ev, data_out, m_data, pd_mode, m_pd,
                 frame_count, m_cnt, frame_err, ee, data_signed, stale);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge dataclk);
      #1;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [17:0] last(input int k);
    return seen[seen.size() - 1 - k];
  endfunction

  task automatic send(input logic [23:0] w, input int nf, input int hi,
                      input int lo, input int gap, input bit coin,
                      input bit hold);
    SYNC = 1'b0;
    SCLK = 1'b0;
    tick(1 + int'($urandom_range(0, 1)));
    for (int i = 0; i < nf; i++) begin
      DIN = (i < 24) ? w[23-i] : 1'($urandom_range(0, 1));
      SCLK = 1'b1;
      tick(hi);
      SCLK = 1'b0;
      if (i == 23) vq.push_back('{cyc + S + 1, w[15:0], w[17:16]});
      if (coin && i == nf - 1) begin
        SYNC = 1'b1;
        tick(gap);
        return;
      end
      tick(lo);
    end
    if (hold) return;
    SYNC = 1'b1;
    if (ERRW == 1 && nf > 0 && nf != 24) eq.push_back(cyc + S + 1);
    tick(gap);
  endtask

  initial begin
    int e0;
    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst data_out", data_out, 32'h8000);
    chk("rst data_signed", data_signed, 32'h0);
    chk("rst pd_mode", pd_mode, 32'h0);
    chk("rst data_valid", data_valid, 32'h0);
    chk("rst frame_err", frame_err, 32'h0);
    chk("rst busy", busy, 32'h0);
    chk("rst frame_count", frame_count, 32'h0);
    tick(S + 3);

    send(24'h008000, 24, 2, 2, 2, 1'b0, 1'b0);
    tick(6);
    chk("midscale word", last(0), 32'h08000);
    chk("midscale signed", data_signed, 32'h0);
    chk("midscale count", frame_count, 32'h1);
    chk("idle busy", busy, 32'h0);

    send(24'h03FFFF, 24, 1, 1, 1, 1'b0, 1'b0);
    send(24'h000000, 24, 1, 1, 1, 1'b0, 1'b0);
    tick(6);
    chk("b2b first", last(1), 32'h3FFFF);
    chk("b2b second", last(0), 32'h00000);
    chk("b2b count", frame_count, 32'h3);

    e0 = err_seen;
    send(24'hFFFFFF, 20, 1, 2, 2, 1'b0, 1'b0);
    tick(6);
    chk("short hold", data_out, 32'h0);
    chk("short count", frame_count, 32'h3);
    chk("short err", err_seen - e0, ERRW);

    e0 = err_seen;
    send(24'hABCDEF, 26, 2, 1, 2, 1'b0, 1'b0);
    tick(6);
    chk("overrun word", last(0), 32'h3CDEF);
    chk("overrun err", err_seen - e0, ERRW);

    e0 = err_seen;
    send(24'h015A5A, 24, 1, 1, 1, 1'b1, 1'b0);
    send(24'h00C3C3, 24, 1, 1, 2, 1'b0, 1'b0);
    tick(6);
    chk("coincide word", last(1), 32'h15A5A);
    chk("after coincide", last(0), 32'h0C3C3);
    chk("coincide err", err_seen - e0, 0);

    send(24'h00FFFF, 12, 2, 2, 1, 1'b0, 1'b1);
    chk("mid busy", busy, 32'h1);
    chk_en = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rst_gen++;
    chk_en = 1'b1;
    tick(S + 2);
    SYNC = 1'b1;
    tick(S + 2);
    send(24'h001234, 24, 2, 2, 2, 1'b0, 1'b0);
    tick(6);
    chk("reset data", data_out, 32'h1234);
    chk("reset count", frame_count, 32'h1);

    for (int k = 0; k < 40; k++) begin
      int nf;
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 24;
      send(24'($urandom), nf, int'($urandom_range(1, 3)),
           int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
           1'b0, 1'b0);
    end
    tick(8);

    force dut.frame_cnt_q = 16'hFFFF;
    frc_gen++;
    tick(2);
    release dut.frame_cnt_q;
    tick(1);
    send(24'h00BEEF, 24, 1, 1, 2, 1'b0, 1'b0);
    tick(6);
    chk("wrap count", frame_count, 32'h0);
    chk("wrap data", data_out, 32'hBEEF);

    tick(10);
    chk("drained", vq.size() + eq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
